keypad_scan_ctrl: RTL and testbench

KEYPAD_SCAN_CTRL -- requirements
Module: keypad_scan_ctrl

---
 rtl/keypad_scan_ctrl.sv | 127 ++++++++++++
 tb/tb_keypad_scan_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: walks active-low columns, debounces press and release,
// and holds one key event until the consumer acknowledges it with key_read.
module keypad_scan_ctrl #(
  parameter int SCAN_CYCLES     = 4,
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic       clk,
  input  logic       RST,
  input  logic [3:0] RowIn,
  output logic [3:0] ColOut,
  output logic       key_valid,
  output logic [3:0] key_code,
  input  logic       key_read
);

  localparam int SW = $clog2(SCAN_CYCLES);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_CYCLES - 1);
  localparam logic [SW-1:0] SETTLE    = SW'(2);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, VALID, RELEASE} state_t;

  state_t        r_state, w_state_nxt;
  logic [3:0]    r_sync1, r_row_s;
  logic [1:0]    r_col, w_col_nxt;
  logic [1:0]    r_row, w_row_nxt;
  logic [SW-1:0] r_dwell, w_dwell_nxt;
  logic [DW-1:0] r_deb, w_deb_nxt;
  logic [3:0]    r_code, w_code_nxt;
  logic [1:0]    w_low_row;
  logic          w_row_low;

  // Lowest-index low row wins when several rows are pulled down together.
  always_comb begin
    w_low_row = 2'd3;
    if (!r_row_s[0])      w_low_row = 2'd0;
    else if (!r_row_s[1]) w_low_row = 2'd1;
    else if (!r_row_s[2]) w_low_row = 2'd2;
  end

  assign w_row_low = ~r_row_s[r_row];

  always_comb begin
    w_state_nxt = r_state;
    w_col_nxt   = r_col;
    w_row_nxt   = r_row;
    w_dwell_nxt = r_dwell;
    w_deb_nxt   = r_deb;
    w_code_nxt  = r_code;
    case (r_state)
      SCAN: begin
        // The first two dwell clocks still carry the previous column's rows.
        if (r_dwell >= SETTLE && r_row_s != 4'hF) begin
          w_state_nxt = DEBOUNCE;
          w_row_nxt   = w_low_row;
          w_deb_nxt   = '0;
        end else if (r_dwell == SCAN_LAST) begin
          w_dwell_nxt = '0;
          w_col_nxt   = r_col + 2'd1;
        end else begin
          w_dwell_nxt = r_dwell + 1'b1;
        end
      end
      DEBOUNCE: begin
        if (w_row_low) begin
          if (r_deb == DEB_LAST) begin
            w_state_nxt = VALID;
            w_code_nxt  = {r_row, r_col};
          end else begin
            w_deb_nxt = r_deb + 1'b1;
          end
        end else begin
          w_state_nxt = SCAN;
          w_dwell_nxt = '0;
        end
      end
      VALID: begin
        if (key_read) begin
          w_state_nxt = RELEASE;
          w_deb_nxt   = '0;
        end
      end
      RELEASE: begin
        if (r_row_s == 4'hF) begin
          if (r_deb == DEB_LAST) begin
            w_state_nxt = SCAN;
            w_col_nxt   = r_col + 2'd1;
            w_dwell_nxt = '0;
          end else begin
            w_deb_nxt = r_deb + 1'b1;
          end
        end else begin
          w_deb_nxt = '0;
        end
      end
      default: w_state_nxt = SCAN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      r_sync1 <= 4'hF;
      r_row_s <= 4'hF;
      r_state <= SCAN;
      r_col   <= '0;
      r_row   <= '0;
      r_dwell <= '0;
      r_deb   <= '0;
      r_code  <= '0;
    end else begin
      r_sync1 <= RowIn;
      r_row_s <= r_sync1;
      r_state <= w_state_nxt;
      r_col   <= w_col_nxt;
      r_row   <= w_row_nxt;
      r_dwell <= w_dwell_nxt;
      r_deb   <= w_deb_nxt;
      r_code  <= w_code_nxt;
    end
  end

  assign ColOut    = ~(4'b0001 << r_col);
  assign key_valid = (r_state == VALID);
  assign key_code  = r_code;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: directed scenarios plus randomized key matrices
// judged against arithmetic predictions of scan position and latency.
module tb_keypad_scan_ctrl;
  localparam int S = 4;
  localparam int D = 8;

  logic        clk = 1'b0;
  logic        RST;
  logic        key_read;
  logic [3:0]  RowIn, ColOut, key_code;
  logic        key_valid;
  logic [3:0]  row_drv;
  logic [15:0] keys;
  logic        use_matrix;
  int          n_checks = 0;
  int          n_fail   = 0;

  keypad_scan_ctrl #(.SCAN_CYCLES(S), .DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .RST(RST), .RowIn(RowIn), .ColOut(ColOut),
    .key_valid(key_valid), .key_code(key_code), .key_read(key_read)
  );

  always #5 clk = ~clk;

  // Physical keypad: a pressed key shorts its row to its column when driven low.
  always_comb begin
    RowIn = row_drv;
    if (use_matrix) begin
      RowIn = 4'hF;
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          if (keys[r*4+c] && !ColOut[c]) RowIn[r] = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
  endtask

  function automatic logic [3:0] col_pat(input int c);
    logic [3:0] v;
    v = 4'b0001 << c;
    return ~v;
  endfunction

  // Presses the given key set from reset and counts clocks until key_valid.
  task automatic press_and_wait(input logic [15:0] mask, input bit jitter, output int cnt);
    use_matrix = 1'b1;
    keys = mask;
    do_reset();
    cnt = 0;
    while (!key_valid && cnt < 200) begin
      key_read = jitter ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
      cnt++;
    end
    key_read = 1'b0;
  endtask

  task automatic read_and_release(output logic v_after, output int rel_cnt, output logic [3:0] col_after);
    logic [3:0] frozen;
    frozen = ColOut;
    key_read = 1'b1;
    tick();
    key_read = 1'b0;
    keys = '0;
    v_after = key_valid;
    rel_cnt = 0;
    while (ColOut == frozen && rel_cnt < 100) begin
      tick();
      rel_cnt++;
    end
    col_after = ColOut;
  endtask

  task automatic test_reset();
    use_matrix = 1'b0;
    row_drv = 4'hF;
    do_reset();
    n_checks++;
    if (ColOut !== 4'b1110) begin n_fail++; $display("FAIL reset_col: got %b expected 1110", ColOut); end
    n_checks++;
    if (key_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", key_valid); end
    n_checks++;
    if (key_code !== 4'd0) begin n_fail++; $display("FAIL reset_code: got %0d expected 0", key_code); end
  endtask

  task automatic test_idle_scan();
    use_matrix = 1'b0;
    row_drv = 4'hF;
    do_reset();
    for (int k = 1; k <= 32; k++) begin
      tick();
      n_checks++;
      if (ColOut !== col_pat((k / S) % 4) || key_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_scan clk %0d: got col %b valid %b expected col %b valid 0",
                 k, ColOut, key_valid, col_pat((k / S) % 4));
      end
    end
  endtask

  task automatic test_clean_press();
    int cnt, rel;
    logic va;
    logic [3:0] ca;
    press_and_wait(16'h0800, 1'b0, cnt);  // row 2, col 3
    n_checks++;
    if (cnt != 3*S + 3 + D) begin n_fail++; $display("FAIL press_latency: got %0d expected %0d", cnt, 3*S + 3 + D); end
    n_checks++;
    if (key_code !== 4'd11) begin n_fail++; $display("FAIL press_code: got %0d expected 11", key_code); end
    tick();
    n_checks++;
    if (ColOut !== 4'b0111 || key_valid !== 1'b1) begin
      n_fail++; $display("FAIL press_frozen: got col %b valid %b expected 0111 1", ColOut, key_valid);
    end
    read_and_release(va, rel, ca);
    n_checks++;
    if (va !== 1'b0) begin n_fail++; $display("FAIL press_read: got valid %b expected 0", va); end
    n_checks++;
    if (rel != 2 + D || ca !== 4'b1110) begin
      n_fail++; $display("FAIL press_release: got %0d clks col %b expected %0d clks col 1110", rel, ca, 2 + D);
    end
  endtask

  task automatic test_bounce();
    bit seen;
    use_matrix = 1'b0;
    row_drv = 4'b1110;
    do_reset();
    tick(); tick(); tick();
    row_drv = 4'hF;
    for (int k = 4; k <= 9; k++) begin
      tick();
      n_checks++;
      if (ColOut !== 4'b1110 || key_valid !== 1'b0) begin
        n_fail++; $display("FAIL bounce_hold clk %0d: got col %b valid %b expected 1110 0", k, ColOut, key_valid);
      end
    end
    tick();
    n_checks++;
    if (ColOut !== 4'b1101) begin n_fail++; $display("FAIL bounce_resume: got %b expected 1101", ColOut); end
    seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (key_valid) seen = 1'b1;
    end
    n_checks++;
    if (seen) begin n_fail++; $display("FAIL bounce_event: got key_valid 1 expected none"); end
  endtask

  task automatic test_multi_row();
    int cnt;
    press_and_wait(16'h0202, 1'b0, cnt);  // rows 0 and 2 on col 1
    n_checks++;
    if (cnt != S + 3 + D) begin n_fail++; $display("FAIL multi_latency: got %0d expected %0d", cnt, S + 3 + D); end
    for (int k = 0; k < 20; k++) begin
      tick();
      n_checks++;
      if (key_valid !== 1'b1 || key_code !== 4'd1) begin
        n_fail++; $display("FAIL multi_hold clk %0d: got valid %b code %0d expected 1 1", k, key_valid, key_code);
      end
    end
  endtask

  task automatic test_reset_in_valid();
    n_checks++;
    if (key_valid !== 1'b1) begin n_fail++; $display("FAIL rst_valid_pre: got %b expected 1", key_valid); end
    RST = 1'b1;
    tick();
    RST = 1'b0;
    n_checks++;
    if (key_valid !== 1'b0 || ColOut !== 4'b1110 || key_code !== 4'd0) begin
      n_fail++; $display("FAIL rst_valid: got valid %b col %b code %0d expected 0 1110 0", key_valid, ColOut, key_code);
    end
  endtask

  task automatic test_random();
    logic [15:0] mask;
    int c, r, cnt, rel, hold;
    logic va;
    logic [3:0] ca;
    for (int it = 0; it < 16; it++) begin
      mask = 16'($urandom & $urandom & $urandom);
      if (mask == 16'h0) mask = 16'h1 << $urandom_range(0, 15);
      c = -1;
      for (int cc = 3; cc >= 0; cc--)
        if (mask[cc] | mask[4+cc] | mask[8+cc] | mask[12+cc]) c = cc;
      r = 3;
      for (int rr = 3; rr >= 0; rr--) if (mask[rr*4+c]) r = rr;
      press_and_wait(mask, 1'b1, cnt);
      n_checks++;
      if (cnt != c*S + 3 + D || key_code !== 4'(r*4 + c) || ColOut !== col_pat(c)) begin
        n_fail++;
        $display("FAIL rand_press mask %h: got %0d clks code %0d col %b expected %0d clks code %0d col %b",
                 mask, cnt, key_code, ColOut, c*S + 3 + D, r*4 + c, col_pat(c));
      end
      hold = $urandom_range(0, 5);
      for (int k = 0; k < hold; k++) tick();
      n_checks++;
      if (key_valid !== 1'b1) begin n_fail++; $display("FAIL rand_hold mask %h: got valid %b expected 1", mask, key_valid); end
      read_and_release(va, rel, ca);
      n_checks++;
      if (va !== 1'b0 || rel != 2 + D || ca !== col_pat((c + 1) % 4)) begin
        n_fail++;
        $display("FAIL rand_release mask %h: got valid %b %0d clks col %b expected 0 %0d clks col %b",
                 mask, va, rel, ca, 2 + D, col_pat((c + 1) % 4));
      end
    end
  endtask

  initial begin
    RST = 1'b1;
    key_read = 1'b0;
    row_drv = 4'hF;
    keys = '0;
    use_matrix = 1'b0;
    @(negedge clk);
    test_reset();
    test_idle_scan();
    test_clean_press();
    test_bounce();
    test_multi_row();
    test_reset_in_valid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
